dmem_responder: RTL

Multi-cycle data-memory responder: the target side of the CPU's load/store interface. It accepts one word-aligned read or write request at a time over a req/ready/ack handshake, inserts a programmable number of wait states, then returns read data or commits write data together with a one-cycle acknowledge. It sits between the CPU's memory-access stage and the data storage array, replacing the zero-latency data memory so the core can be exercised against realistic memory latency.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the CPU load/store port.
// Accepts one word-aligned read or write at a time, waits WAIT_CYCLES cycles,
// then commits the access and pulses ack_o for one cycle.
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - asynchronous active-high reset
//   req_i    - request valid (accepted only while ready_o=1)
//   we_i     - 1 = write, 0 = read, sampled with req_i
//   addr_i   - byte address, must be word aligned and inside the array
//   wdata_i  - write data, sampled with req_i
//   ready_o  - responder can accept a request this cycle
//   ack_o    - one-cycle completion pulse
//   rdata_o  - read data, non-zero only while ack_o=1
//   err_o    - misaligned or out-of-range request, only while ack_o=1
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DepthW = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WaitW  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // The commit edge can be the accept edge itself (WAIT_CYCLES=0), so the
  // access is taken from the live inputs in IDLE and from the latches later.
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_err;
  logic [AW-1:0] c_idx;
  logic          commit;
  logic          mem_we;

  always_comb begin
    c_we    = (state_q == StIdle) ? we_i    : we_q;
    c_addr  = (state_q == StIdle) ? addr_i  : addr_q;
    c_wdata = (state_q == StIdle) ? wdata_i : wdata_q;
    // Full 30-bit index compare: out-of-range addresses are flagged, never wrapped.
    c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DepthW);
    c_idx   = c_addr[AW+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    ack_d   = 1'b0;
    rdata_d = 32'h0;
    err_d   = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = WaitW;
          if (WaitW == 4'd0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase

    if (commit) begin
      ack_d = 1'b1;
      err_d = c_err;
      if (!c_err && !c_we) begin
        rdata_d = mem[c_idx];
      end
    end
  end

  assign mem_we = commit && c_we && !c_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; gating with rst_i drops a write whose commit edge
  // coincides with reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign ready_o = ready_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule
